adding_cpu_sequencer: RTL and testbench

Control unit for the 8-bit adding CPU: a fetch/decode/execute FSM that sequences the PC, IR, AC and ALU datapath and the shared 64x8 memory bus.

---
 rtl/adding_cpu_sequencer_pkg.sv | 51 +++++
 rtl/adding_cpu_sequencer_mem_wait_timer.sv | 30 +++
 rtl/adding_cpu_sequencer.sv | 137 +++++++++++++
 tb/tb_adding_cpu_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adding_cpu_sequencer_pkg.sv
// Shared definitions for the adding CPU control unit: opcodes, the sequencer
// state encoding and the bundle of datapath control strobes.
package adding_cpu_sequencer_pkg;

    // Opcode field IR[7:6]; the assembler and the datapath use the same values.
    localparam logic [1:0] OP_LDA = 2'b00;
    localparam logic [1:0] OP_STA = 2'b01;
    localparam logic [1:0] OP_JMP = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    // Width of the memory wait-state counter; 0..15 extra cycles per access.
    localparam int WAIT_W = 4;

    // Sequencer states. RST must encode as zero.
    typedef enum logic [2:0] {
        ST_RST     = 3'd0,
        ST_IDLE    = 3'd1,
        ST_FETCH   = 3'd2,
        ST_DECODE  = 3'd3,
        ST_EXEC_RD = 3'd4,
        ST_EXEC_WR = 3'd5
    } seq_state_t;

    // Everything the sequencer drives into the datapath, plus busy.
    typedef struct packed {
        logic sel_pc;
        logic rd_mem;
        logic wr_mem;
        logic drv_ac;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic ld_ac;
        logic alu_add;
        logic busy;
    } seq_ctrl_t;

    // Quiet control word: address from PC, nothing strobed, not busy.
    function automatic seq_ctrl_t ctrl_quiet();
        seq_ctrl_t c;
        c         = '0;
        c.sel_pc  = 1'b1;
        return c;
    endfunction

    // States that own the memory bus and therefore run the wait timer.
    function automatic logic is_mem_state(seq_state_t s);
        return (s == ST_FETCH) || (s == ST_EXEC_RD) || (s == ST_EXEC_WR);
    endfunction

endpackage

// File: rtl/adding_cpu_sequencer_mem_wait_timer.sv
// Wait-state timer for one memory access. The count restarts at zero whenever
// it is cleared and flags the final cycle of the access with `last`.
module adding_cpu_sequencer_mem_wait_timer
    import adding_cpu_sequencer_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last
);

    logic [WAIT_W-1:0] count;

    // Count cycles spent inside an access; clear wins over enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == WAIT_W'(MEM_WAIT));

endmodule

// File: rtl/adding_cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit adding CPU. Drives the PC, IR,
// AC and ALU control strobes and the shared memory bus, stretching every
// memory access by MEM_WAIT wait states. `run` is honoured only at
// instruction boundaries so a pause never cuts an instruction short.
module adding_cpu_sequencer
    import adding_cpu_sequencer_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [1:0]       op_code,
    output logic             sel_pc,
    output logic             rd_mem,
    output logic             wr_mem,
    output logic             drv_ac,
    output logic             ld_ir,
    output logic             inc_pc,
    output logic             ld_pc,
    output logic             ld_ac,
    output logic             alu_add,
    output logic             busy,
    output logic [CNT_W-1:0] instr_cnt
);

    seq_state_t state;
    seq_state_t boundary_state;
    logic       access_last;
    logic       timer_enable;
    logic       timer_clear;
    logic       retire;
    seq_ctrl_t  ctrl;

    // The timer advances only while an access still has cycles left; any
    // other cycle clears it so the next access always starts from zero.
    assign timer_enable = is_mem_state(state) && !access_last;
    assign timer_clear  = !timer_enable;

    adding_cpu_sequencer_mem_wait_timer #(
        .MEM_WAIT (MEM_WAIT)
    ) u_mem_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .last   (access_last)
    );

    // Where an instruction goes once it is done: straight into the next fetch
    // or park in IDLE.
    assign boundary_state = run ? ST_FETCH : ST_IDLE;

    // An instruction retires on the edge leaving jmp's DECODE or the final
    // cycle of its execute access.
    assign retire = ((state == ST_DECODE) && (op_code == OP_JMP)) ||
                    (((state == ST_EXEC_RD) || (state == ST_EXEC_WR)) && access_last);

    // State register and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RST;
            instr_cnt <= '0;
        end else begin
            if (retire) begin
                instr_cnt <= instr_cnt + 1'b1;
            end
            case (state)
                ST_RST:  state <= ST_IDLE;
                ST_IDLE: state <= boundary_state;
                ST_FETCH: begin
                    if (access_last) begin
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (op_code)
                        OP_JMP:  state <= boundary_state;
                        OP_STA:  state <= ST_EXEC_WR;
                        default: state <= ST_EXEC_RD;
                    endcase
                end
                ST_EXEC_RD, ST_EXEC_WR: begin
                    if (access_last) begin
                        state <= boundary_state;
                    end
                end
                default: state <= ST_RST;
            endcase
        end
    end

    // Decode the control word from the state and the access-final flag; the
    // only other term is the opcode, which comes from the IR register.
    always_comb begin
        ctrl      = ctrl_quiet();
        ctrl.busy = (state != ST_RST) && (state != ST_IDLE);
        case (state)
            ST_FETCH: begin
                ctrl.rd_mem = 1'b1;
                ctrl.ld_ir  = access_last;
                ctrl.inc_pc = access_last;
            end
            ST_DECODE: begin
                ctrl.sel_pc = 1'b0;
                ctrl.ld_pc  = (op_code == OP_JMP);
            end
            ST_EXEC_RD: begin
                ctrl.sel_pc  = 1'b0;
                ctrl.rd_mem  = 1'b1;
                ctrl.ld_ac   = access_last;
                ctrl.alu_add = access_last && (op_code == OP_ADD);
            end
            ST_EXEC_WR: begin
                ctrl.sel_pc = 1'b0;
                ctrl.wr_mem = 1'b1;
                ctrl.drv_ac = 1'b1;
            end
            default: begin
                ctrl.sel_pc = 1'b1;
            end
        endcase
    end

    assign sel_pc  = ctrl.sel_pc;
    assign rd_mem  = ctrl.rd_mem;
    assign wr_mem  = ctrl.wr_mem;
    assign drv_ac  = ctrl.drv_ac;
    assign ld_ir   = ctrl.ld_ir;
    assign inc_pc  = ctrl.inc_pc;
    assign ld_pc   = ctrl.ld_pc;
    assign ld_ac   = ctrl.ld_ac;
    assign alu_add = ctrl.alu_add;
    assign busy    = ctrl.busy;

endmodule

// File: tb/tb_adding_cpu_sequencer.sv
// Self-checking bench for adding_cpu_sequencer. Two sequencers (MEM_WAIT=0 and
// MEM_WAIT=2) each drive a small behavioural PC/IR/AC/memory datapath so the
// opcode seen by the sequencer comes from a real instruction stream.
module tb_adding_cpu_sequencer;
    import adding_cpu_sequencer_pkg::*;

    // Expected strobe words {sel_pc,rd_mem,wr_mem,drv_ac,ld_ir,inc_pc,ld_pc,ld_ac,alu_add,busy}.
    localparam logic [9:0] P_IDLE       = 10'b1000000000;
    localparam logic [9:0] P_FETCH_MID  = 10'b1100000001;
    localparam logic [9:0] P_FETCH_LAST = 10'b1100110001;
    localparam logic [9:0] P_DECODE     = 10'b0000000001;
    localparam logic [9:0] P_JMP        = 10'b0000001001;
    localparam logic [9:0] P_RD_MID     = 10'b0100000001;
    localparam logic [9:0] P_LDA_LAST   = 10'b0100000101;
    localparam logic [9:0] P_ADD_LAST   = 10'b0100000111;
    localparam logic [9:0] P_WR         = 10'b0011000001;

    typedef struct {
        int          inst;
        logic        rst;
        logic        run;
        logic [9:0]  exp;
        logic [15:0] cnt;
        logic        pc_chk;
        logic [5:0]  pc;
    } vec_t;

    logic        clk;
    logic        reset   [2];
    logic        run     [2];
    logic        load    [2];
    logic [7:0]  image   [2][64];
    logic [5:0]  pc_init [2];
    logic [9:0]  obs     [2];
    logic [15:0] cnt_obs [2];
    logic [5:0]  pc_obs  [2];
    logic [7:0]  m0c     [2];
    int          wcnt    [2];

    int   checks;
    int   errors;
    int   inv_viol = 0;
    vec_t vecs[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : g_cpu
        logic        sel_pc, rd_mem, wr_mem, drv_ac, ld_ir, inc_pc, ld_pc, ld_ac, alu_add, busy;
        logic [15:0] instr_cnt;
        logic [7:0]  mem [64];
        logic [5:0]  pc;
        logic [7:0]  ir;
        logic [7:0]  ac;
        logic [5:0]  addr;
        int          wr_c;

        adding_cpu_sequencer #(
            .MEM_WAIT (g * 2),
            .CNT_W    (16)
        ) dut (
            .clk       (clk),
            .reset     (reset[g]),
            .run       (run[g]),
            .op_code   (ir[7:6]),
            .sel_pc    (sel_pc),
            .rd_mem    (rd_mem),
            .wr_mem    (wr_mem),
            .drv_ac    (drv_ac),
            .ld_ir     (ld_ir),
            .inc_pc    (inc_pc),
            .ld_pc     (ld_pc),
            .ld_ac     (ld_ac),
            .alu_add   (alu_add),
            .busy      (busy),
            .instr_cnt (instr_cnt)
        );

        assign addr = sel_pc ? pc : ir[5:0];

        // Behavioural datapath obeying the sequencer's strobes.
        always @(posedge clk) begin
            if (load[g]) begin
                for (int i = 0; i < 64; i++) mem[i] <= image[g][i];
                pc   <= pc_init[g];
                ir   <= 8'h00;
                ac   <= 8'h00;
                wr_c <= 0;
            end else begin
                if (ld_ir) ir <= mem[addr];
                if (ld_pc) pc <= ir[5:0];
                else if (inc_pc) pc <= pc + 6'd1;
                if (ld_ac) ac <= alu_add ? ac + mem[addr] : mem[addr];
                if (wr_mem && drv_ac) mem[addr] <= ac;
                if (wr_mem && addr == 6'h0C) wr_c <= wr_c + 1;
            end
        end

        assign obs[g]     = {sel_pc, rd_mem, wr_mem, drv_ac, ld_ir, inc_pc, ld_pc, ld_ac, alu_add, busy};
        assign cnt_obs[g] = instr_cnt;
        assign pc_obs[g]  = pc;
        assign m0c[g]     = mem[12];
        assign wcnt[g]    = wr_c;
    end

    // Invariant monitor: bus strobes and PC strobes stay mutually exclusive.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if ((obs[g][8] && obs[g][7]) || (obs[g][6] != obs[g][7]) || (obs[g][4] && obs[g][3])) begin
                inv_viol <= inv_viol + 1;
                $display("[TB] invariant broken on instance %0d at %0t: %b", g, $time, obs[g]);
            end
        end
    end

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        reset[v.inst] = v.rst;
        run[v.inst]   = v.run;
    endtask

    task automatic addVec(int inst, logic rst, logic r, logic [9:0] exp, logic [15:0] cnt,
                          logic pc_chk, logic [5:0] pc);
        vec_t v;
        v.inst = inst; v.rst = rst; v.run = r; v.exp = exp;
        v.cnt = cnt; v.pc_chk = pc_chk; v.pc = pc;
        vecs.push_back(v);
    endtask

    // One whole instruction as hand-derived per-cycle expectations.
    task automatic addInstr(int inst, int w, logic [1:0] op, logic [15:0] cnt,
                            logic run_fetch, logic run_rest, logic [5:0] pc);
        for (int i = 0; i < w; i++) addVec(inst, 0, run_fetch, P_FETCH_MID, cnt, i == 0, pc);
        addVec(inst, 0, run_fetch, P_FETCH_LAST, cnt, w == 0, pc);
        if (op == OP_JMP) begin
            addVec(inst, 0, run_rest, P_JMP, cnt, 0, 6'd0);
        end else begin
            addVec(inst, 0, run_rest, P_DECODE, cnt, 0, 6'd0);
            for (int i = 0; i < w; i++)
                addVec(inst, 0, run_rest, (op == OP_STA) ? P_WR : P_RD_MID, cnt, 0, 6'd0);
            addVec(inst, 0, run_rest,
                   (op == OP_STA) ? P_WR : ((op == OP_ADD) ? P_ADD_LAST : P_LDA_LAST),
                   cnt, 0, 6'd0);
        end
    endtask

    task automatic runRange(int first, int last_idx);
        for (int k = first; k < last_idx; k++) begin
            applyStimulus(vecs[k]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d strobes", k), 32'(obs[vecs[k].inst]), 32'(vecs[k].exp));
            checkOutput($sformatf("vec%0d instr_cnt", k), 32'(cnt_obs[vecs[k].inst]), 32'(vecs[k].cnt));
            if (vecs[k].pc_chk)
                checkOutput($sformatf("vec%0d pc", k), 32'(pc_obs[vecs[k].inst]), 32'(vecs[k].pc));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int   t1_end;
        int   t2_end;
        logic found;
        int   snap;

        checks = 0;
        errors = 0;
        for (int g = 0; g < 2; g++) begin
            reset[g] = 1'b1; run[g] = 1'b0; load[g] = 1'b1; pc_init[g] = 6'd0;
            for (int i = 0; i < 64; i++) image[g][i] = 8'h00;
            image[g][0]  = 8'h0A;   // lda 0A
            image[g][1]  = 8'hCB;   // add 0B
            image[g][2]  = 8'h4C;   // sta 0C
            image[g][3]  = 8'h80;   // jmp 00
            image[g][10] = 8'h05;
            image[g][11] = 8'h03;
        end

        // Test 1 and 2/4 vector tables.
        addVec(0, 0, 0, P_IDLE, 16'd0, 0, 6'd0);
        addVec(0, 0, 1, P_IDLE, 16'd0, 0, 6'd0);
        addInstr(0, 0, OP_LDA, 16'd0, 1, 1, 6'd0);
        addInstr(0, 0, OP_ADD, 16'd1, 1, 1, 6'd1);
        addInstr(0, 0, OP_STA, 16'd2, 1, 1, 6'd2);
        addInstr(0, 0, OP_JMP, 16'd3, 1, 1, 6'd3);
        addVec(0, 0, 1, P_FETCH_LAST, 16'd4, 1, 6'd0);
        t1_end = vecs.size();
        addVec(1, 0, 0, P_IDLE, 16'd0, 0, 6'd0);
        addVec(1, 0, 1, P_IDLE, 16'd0, 0, 6'd0);
        addInstr(1, 2, OP_LDA, 16'd0, 1, 1, 6'd0);
        addInstr(1, 2, OP_ADD, 16'd1, 1, 1, 6'd1);
        addInstr(1, 2, OP_STA, 16'd2, 1, 1, 6'd2);
        addInstr(1, 2, OP_JMP, 16'd3, 1, 1, 6'd3);
        addInstr(1, 2, OP_LDA, 16'd4, 1, 1, 6'd0);
        addInstr(1, 2, OP_ADD, 16'd5, 1, 0, 6'd1);
        addVec(1, 0, 0, P_IDLE, 16'd6, 0, 6'd0);
        addVec(1, 0, 1, P_IDLE, 16'd6, 0, 6'd0);
        addInstr(1, 2, OP_STA, 16'd6, 0, 0, 6'd2);
        addVec(1, 0, 0, P_IDLE, 16'd7, 0, 6'd0);
        addVec(1, 0, 0, P_IDLE, 16'd7, 1, 6'd3);
        t2_end = vecs.size();

        @(posedge clk);
        #1;
        load[0] = 1'b0;

        $display("[TB] test 1: MEM_WAIT=0 program");
        runRange(0, t1_end);
        checkOutput("t1 mem[0C]", 32'(m0c[0]), 32'h08);

        $display("[TB] test 3: reset during write");
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (obs[0][7] === 1'b1) found = 1'b1;
        end
        checkOutput("t3 reached EXEC_WR", 32'(found), 32'd1);
        reset[0] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t3 RST strobes", 32'(obs[0]), 32'(P_IDLE));
        checkOutput("t3 RST instr_cnt", 32'(cnt_obs[0]), 32'd0);
        snap = wcnt[0];
        reset[0] = 1'b0;
        run[0] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t3 IDLE strobes", 32'(obs[0]), 32'(P_IDLE));
        @(posedge clk);
        #1;
        checkOutput("t3 still IDLE", 32'(obs[0]), 32'(P_IDLE));
        checkOutput("t3 no further write", 32'(wcnt[0]), 32'(snap));
        run[0] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t3 FETCH after IDLE", 32'(obs[0]), 32'(P_FETCH_LAST));
        run[0] = 1'b0;
        reset[0] = 1'b1;

        $display("[TB] test 2/4: MEM_WAIT=2 program, pause and single step");
        load[1] = 1'b0;
        runRange(t1_end, t2_end);
        checkOutput("t2 mem[0C]", 32'(m0c[1]), 32'h08);

        $display("[TB] test 5: jmp 3F at PC 3F");
        for (int i = 0; i < 64; i++) image[0][i] = 8'h00;
        image[0][63] = 8'hBF;
        pc_init[0] = 6'h3F;
        load[0] = 1'b1;
        @(posedge clk);
        #1;
        load[0] = 1'b0;
        reset[0] = 1'b0;
        run[0] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t5 loop%0d fetch strobes", k), 32'(obs[0]), 32'(P_FETCH_LAST));
            checkOutput($sformatf("t5 loop%0d fetch pc", k), 32'(pc_obs[0]), 32'h3F);
            @(posedge clk);
            #1;
            checkOutput($sformatf("t5 loop%0d jmp strobes", k), 32'(obs[0]), 32'(P_JMP));
            checkOutput($sformatf("t5 loop%0d wrapped pc", k), 32'(pc_obs[0]), 32'h00);
            @(posedge clk);
            #1;
        end
        reset[0] = 1'b1;

        $display("[TB] test 6: free run under invariant monitor");
        run[1] = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        checkOutput("t6 progress", 32'(cnt_obs[1] > 16'd7), 32'd1);
        checkOutput("invariants", 32'(inv_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
